// File: rtl/psc_arb_pkg.sv
// Shared types and bounds for the packet stream arbiter: FSM state encoding,
// requester-count limits and default timing/length parameters.
package psc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int N_REQ_MIN   = 2;
  localparam int N_REQ_MAX   = 8;
  localparam int GAP_CYC_DEF = 1;
  localparam int GAP_CYC_MAX = 15;
  localparam int MAX_LEN_DEF = 64;
  localparam int MAX_LEN_MAX = 127;

endpackage

// File: rtl/psc_rr_pick.sv
// Combinational round-robin selector: scans requesters starting one past the
// pointer (wrapping) and returns the first valid one as one-hot, index and any.
module psc_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDW-1:0]   idx_o,
  output logic             any_o
);

  // The pointer holds the last winner, so the scan starts at offset 1.
  always_comb begin
    int             cand;
    logic [IDW-1:0] candIdx;
    cand    = 0;
    candIdx = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand    = (int'(ptr_i) + off) % N_REQ;
      candIdx = IDW'(cand);
      if (!any_o && valid_i[candIdx]) begin
        grant_o[candIdx] = 1'b1;
        idx_o            = candIdx;
        any_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psc_stream_arb.sv
// Round-robin packet arbiter muxing N_REQ byte streams onto one shared path.
// Optional packet-length watchdog enabled by defining PSC_ARB_MAXLEN_EN.
module psc_stream_arb
  import psc_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ*8-1:0] iv_req_data,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         ov_data,
  output logic               o_data_wr,
  output logic [IDW-1:0]     ov_src_id,
  output logic               o_sop,
  output logic               o_eop,
  output logic               o_busy,
  output logic               o_err
);

  if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX || IDW != $clog2(N_REQ) ||
      GAP_CYC < 0 || GAP_CYC > GAP_CYC_MAX || MAX_LEN < 1 || MAX_LEN > MAX_LEN_MAX) begin : gBadConfig
    $error("psc_stream_arb: illegal parameter combination");
  end

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0] grantOh_q, grantOh_d;
  logic [IDW-1:0]   rrPtr_q, rrPtr_d;
  logic [3:0]       gapCnt_q, gapCnt_d;
  logic             first_q, first_d;

  logic [N_REQ-1:0] pickGrant;
  logic [IDW-1:0]   pickIdx;
  logic             pickAny;

  logic             accept;
  logic [7:0]       curByte;
  logic             curLast;
  logic             endPkt;

  logic [7:0]       data_q;
  logic             wr_q, sop_q, eop_q;
  logic [IDW-1:0]   src_q;

  psc_rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) uPick (
    .valid_i (i_req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .any_o   (pickAny)
  );

  assign accept  = (state_q == XFER) && i_req_valid[grant_q];
  assign curByte = iv_req_data[{grant_q, 3'b000} +: 8];
  assign curLast = i_req_last[grant_q];

`ifdef PSC_ARB_MAXLEN_EN
  logic [6:0] byteCnt_q;
  logic       lenHit;
  logic       err_q;

  // A packet hitting MAX_LEN without last is cut there and flagged.
  assign lenHit = (byteCnt_q == 7'(MAX_LEN - 1));
  assign endPkt = curLast | lenHit;
  assign o_err  = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byteCnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q != XFER) byteCnt_q <= '0;
      else if (accept)     byteCnt_q <= endPkt ? 7'd0 : byteCnt_q + 7'd1;
      if (accept && lenHit && !curLast) err_q <= 1'b1;
    end
  end
`else
  assign endPkt = curLast;
  assign o_err  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      grantOh_q <= '0;
      rrPtr_q   <= IDW'(N_REQ - 1);
      gapCnt_q  <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      grantOh_q <= grantOh_d;
      rrPtr_q   <= rrPtr_d;
      gapCnt_q  <= gapCnt_d;
      first_q   <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    grantOh_d = grantOh_q;
    rrPtr_d   = rrPtr_q;
    gapCnt_d  = gapCnt_q;
    first_d   = first_q;
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          grant_d   = pickIdx;
          grantOh_d = pickGrant;
          first_d   = 1'b1;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          first_d = 1'b0;
          if (endPkt) begin
            rrPtr_d  = grant_q;
            gapCnt_d = '0;
            state_d  = (GAP_CYC > 0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (gapCnt_q == 4'(GAP_CYC - 1)) state_d = IDLE;
        else                             gapCnt_d = gapCnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state_q == XFER) ? grantOh_q : '0;
    o_busy      = (state_q != IDLE);
  end

  // Shared-path output stage; data and id only update on a moved byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      wr_q   <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      src_q  <= '0;
    end else begin
      wr_q  <= accept;
      sop_q <= accept && first_q;
      eop_q <= accept && endPkt;
      if (accept) begin
        data_q <= curByte;
        src_q  <= grant_q;
      end
    end
  end

  assign ov_data   = data_q;
  assign o_data_wr = wr_q;
  assign o_sop     = sop_q;
  assign o_eop     = eop_q;
  assign ov_src_id = src_q;

endmodule
